// File: rtl/data_memory_hs.sv
// data_memory_hs: handshaked, word-addressed data memory for the multicycle core.
// One load or store per transaction over valid/ready request and response channels.
// Stores write only the byte lanes selected by req_be. Out-of-range addresses flag
// resp_err and never touch memory. The response appears LATENCY edges after the accept edge.
// Optional build macro DMEM_CLEAR_EN: after reset the whole array is swept to zero,
// one word per edge, before the first request is accepted.
module data_memory_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              wr_en;

  assign in_range = ({1'b0, req_addr} < DEPTH_CMP);
  assign idx      = req_addr[IDX_W-1:0];
  // Gated with rst_n so a store presented while reset is held cannot commit
  assign accept   = rst_n && (state == IDLE) && req_valid && req_ready;
  assign wr_en    = accept && req_we && in_range;

`ifdef DMEM_CLEAR_EN
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  clr_addr;
  logic              clr_we;

  assign clr_we = rst_n && (state == CLEAR);

  // Storage array: zero sweep during CLEAR, byte-lane writes on an accepted in-range store
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end
`else
  // Simulation preload of words 0 and 1; the array itself is never reset
  logic [DATA_W-1:0] mem [DEPTH] = '{0: DATA_W'(100), 1: DATA_W'(100), default: '0};

  // Storage array: byte-lane writes on an accepted in-range store
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end
`endif

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_CLEAR_EN
      state     <= CLEAR;
      req_ready <= 1'b0;
      clr_addr  <= '0;
`else
      state     <= IDLE;
      req_ready <= 1'b1;
`endif
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= !in_range;
            resp_rdata <= (!req_we && in_range) ? mem[idx] : '0;
            lat_cnt    <= CNT_W'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
`ifdef DMEM_CLEAR_EN
        CLEAR: begin
          if (clr_addr == IDX_W'(DEPTH - 1)) begin
            clr_addr  <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed, table-driven bench for data_memory_hs.
// Honours DMEM_CLEAR_EN (bench then uses DEPTH=16 and expects the zero sweep).
module tb_data_memory_hs;

  localparam int TB_LAT = 2;
`ifdef DMEM_CLEAR_EN
  localparam int         TB_DEPTH  = 16;
  localparam logic [15:0] PRELOAD  = 16'h0000;
  localparam logic       RST_READY = 1'b0;
  localparam int         READY_EDGES = TB_DEPTH;
`else
  localparam int         TB_DEPTH  = 256;
  localparam logic [15:0] PRELOAD  = 16'h0064;
  localparam logic       RST_READY = 1'b1;
  localparam int         READY_EDGES = 0;
`endif
  localparam logic [15:0] WRAP_ADDR = 16'(300 % TB_DEPTH);
  localparam logic [15:0] TOP_ADDR  = 16'(TB_DEPTH - 1);
  localparam logic [15:0] OOR_ADDR  = 16'(TB_DEPTH);

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_memory_hs #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (TB_DEPTH),
    .LATENCY(TB_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string name, input logic we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [1:0] be,
                              input logic [15:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  // Called just after the accept edge: checks latency, response, handshake, return to idle
  task automatic wait_response(input string name, input logic [15:0] exp_rdata,
                               input logic exp_err);
    for (int k = 0; k < TB_LAT; k++) begin
      @(negedge clk);
      check_output({name, " busy"}, 32'({resp_valid, req_ready}), 32'(2'b00));
    end
    @(negedge clk);
    check_output({name, " valid"}, 32'({resp_valid, req_ready}), 32'(2'b10));
    check_output({name, " rdata"}, 32'(resp_rdata), 32'(exp_rdata));
    check_output({name, " err"}, 32'(resp_err), 32'(exp_err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_output({name, " idle"}, 32'({resp_valid, resp_rdata, resp_err, req_ready}),
                 32'({1'b0, 16'h0000, 1'b0, 1'b1}));
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    check_output({v.name, " ready"}, 32'(req_ready), 32'(1));
    apply_stimulus(v.we, v.addr, v.wdata, v.be);
    @(posedge clk);
    #1;
    // Scramble request fields so late sampling would show up
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_be    = ~v.be;
    wait_response(v.name, v.exp_rdata, v.exp_err);
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    #1;
    while (!req_ready && edges < 4 * TB_DEPTH + 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;

    vecs.push_back(mk("load0_preload", 1'b0, 16'd0,   16'h0000, 2'b00, PRELOAD,  1'b0));
    vecs.push_back(mk("load1_preload", 1'b0, 16'd1,   16'h0000, 2'b00, PRELOAD,  1'b0));
    vecs.push_back(mk("st5_full",      1'b1, 16'd5,   16'hABCD, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk("st5_hi",        1'b1, 16'd5,   16'h1200, 2'b10, 16'h0000, 1'b0));
    vecs.push_back(mk("ld5_merge",     1'b0, 16'd5,   16'h0000, 2'b00, 16'h12CD, 1'b0));
    vecs.push_back(mk("st_wrap",       1'b1, WRAP_ADDR, 16'h5A5A, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk("ld300_oor",     1'b0, 16'd300, 16'h0000, 2'b00, 16'h0000, 1'b1));
    vecs.push_back(mk("st300_oor",     1'b1, 16'd300, 16'hFFFF, 2'b11, 16'h0000, 1'b1));
    vecs.push_back(mk("ld_wrap",       1'b0, WRAP_ADDR, 16'h0000, 2'b00, 16'h5A5A, 1'b0));
    vecs.push_back(mk("st6_full",      1'b1, 16'd6,   16'h1111, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk("st6_be0",       1'b1, 16'd6,   16'hBEEF, 2'b00, 16'h0000, 1'b0));
    vecs.push_back(mk("st6_lo",        1'b1, 16'd6,   16'h2233, 2'b01, 16'h0000, 1'b0));
    vecs.push_back(mk("ld6",           1'b0, 16'd6,   16'h0000, 2'b00, 16'h1133, 1'b0));
    vecs.push_back(mk("st_top",        1'b1, TOP_ADDR, 16'h7777, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk("ld_top",        1'b0, TOP_ADDR, 16'h0000, 2'b00, 16'h7777, 1'b0));
    vecs.push_back(mk("ld_depth_oor",  1'b0, OOR_ADDR, 16'h0000, 2'b00, 16'h0000, 1'b1));
    vecs.push_back(mk("ld_ffff_oor",   1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ctrl", 32'({req_ready, resp_valid, resp_err}),
                 32'({RST_READY, 1'b0, 1'b0}));
    check_output("reset_rdata", 32'(resp_rdata), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(edges);
    check_output("ready_edges", 32'(edges), 32'(READY_EDGES));

    // Directed vector table
    foreach (vecs[i]) run_txn(vecs[i]);

    // Response stall: held new request must wait for handshake and return to idle
    @(negedge clk);
    apply_stimulus(1'b0, 16'd5, 16'h0000, 2'b00);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 16'd7, 16'h4242, 2'b11);
    for (int k = 0; k < TB_LAT; k++) begin
      @(negedge clk);
      check_output("stall busy", 32'({resp_valid, req_ready}), 32'(2'b00));
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_output("stall hold", 32'({resp_valid, req_ready, resp_err, resp_rdata}),
                   32'({1'b1, 1'b0, 1'b0, 16'h12CD}));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_output("stall idle", 32'({resp_valid, req_ready}), 32'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'h0000;
    wait_response("stall_store7", 16'h0000, 1'b0);
    run_txn(mk("ld7_after_stall", 1'b0, 16'd7, 16'h0000, 2'b00, 16'h4242, 1'b0));

    // Reset in the middle of WAIT aborts the transaction with no response
    @(negedge clk);
    apply_stimulus(1'b0, 16'd5, 16'h0000, 2'b00);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midreset_ctrl", 32'({resp_valid, req_ready}), 32'({1'b0, RST_READY}));
    check_output("midreset_rdata", 32'(resp_rdata), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(edges);
    check_output("midreset_ready_edges", 32'(edges), 32'(READY_EDGES));
    run_txn(mk("ld0_after_reset", 1'b0, 16'd0, 16'h0000, 2'b00, PRELOAD, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised, handshaked successor to the processor's 16-bit data memory. Serves one load or store per transaction over a valid/ready request channel and a valid/ready response channel.
- Adds byte-lane write enables, configurable access latency, and out-of-range detection.
- Sits between the multicycle control unit's MEM stage and the word-addressed data store. The FSM holds in MEM until resp_valid.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 16, address width in bits.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2^ADDR_W.
- LATENCY, 2, accepting edge to resp_valid, in cycles; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte-lane enables for stores; bit i selects bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and for errors.
- resp_err  out  1  address was out of range (req_addr >= DEPTH).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Outputs: req_ready=1 (0 if DMEM_CLEAR_EN), resp_valid=0, resp_rdata=0, resp_err=0.
  - Latency counter is cleared.
  - Memory contents are NOT reset, except under DMEM_CLEAR_EN.
  - A reset mid-transaction aborts it. A store already committed stays committed. No response is issued.
- States: IDLE, WAIT, RESP, plus CLEAR under DMEM_CLEAR_EN.
- IDLE:
  - req_ready=1.
  - Accept occurs on a rising edge with req_valid && req_ready.
  - At the accept edge:
    - Latch the error flag: addr >= DEPTH.
    - Store: if in range, write memory with the enabled bytes only. Disabled bytes keep their old value.
    - Load: if in range, capture memory[addr] into the response data register. If out of range, capture 0.
    - Store: capture 0 as response data.
    - Load counter = LATENCY-1; go to WAIT.
  - req_addr, req_wdata, req_be and req_we are sampled only at the accept edge.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - When counter == 0 at an edge, go to RESP.
  - Net effect: resp_valid is first high in the cycle following edge N+LATENCY, where N is the accept edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - Holds until an edge with resp_ready=1, then goes to IDLE.
  - resp_valid, resp_rdata and resp_err return to 0 after that edge.
  - req_ready rises only after the return to IDLE. There is no overlap: maximum throughput is one transaction per LATENCY+2 cycles.
- Stores always produce a response (an acknowledge) with resp_rdata=0.
- Out of range:
  - Store: suppressed, resp_err=1.
  - Load: resp_rdata=0, resp_err=1.
  - No memory index wraps.
- req_valid while req_ready=0 is ignored. The requester holds its request until accepted.
- resp_ready while resp_valid=0 is ignored.
- A store with req_be all zeros is a legal no-op and still acknowledges.

Optional Feature:
- DMEM_CLEAR_EN defined:
  - Reset release enters CLEAR.
  - An address counter runs from 0 to DEPTH-1, writing 0 to one word per edge.
  - req_ready=0 throughout CLEAR.
  - After the edge that writes word DEPTH-1, go to IDLE. req_ready rises after exactly DEPTH edges.
  - Reset during CLEAR restarts the sweep from 0.
- DMEM_CLEAR_EN undefined:
  - No CLEAR state.
  - Memory is uninitialised apart from simulation preload: words 0 and 1 = 16'd100 when DATA_W=16.
  - req_ready=1 immediately after reset release.

Test Plan:
1. Defaults; after reset, load addr 0 accepted at edge N -> resp_valid first high after edge N+2, resp_rdata=0x0064, resp_err=0; req_ready=0 until the cycle after the resp handshake.
2. Store addr 5 wdata 0xABCD be=2'b11, then store addr 5 wdata 0x1200 be=2'b10, then load addr 5 -> both stores ack with rdata 0; load returns 0x12CD.
3. Load addr 300 (DEPTH=256) -> resp_err=1, resp_rdata=0; store addr 300 wdata 0xFFFF, then load addr 44 (300 mod 256) -> resp_err=0, returns the prior value (no wrap).
4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable throughout; new req_valid ignored; the request is accepted only after the handshake and the return to IDLE.
5. LATENCY=1 and LATENCY=4 builds -> resp_valid first high after edge N+1 and edge N+4 respectively.
6. DMEM_CLEAR_EN with DEPTH=16: assert rst_n low mid-WAIT -> resp_valid=0 and req_ready=0 immediately; after release, req_ready rises after 16 edges; load addr 0 -> 0x0000.
